// File: rtl/spi_pkg.sv
// Shared SPI definitions for the target interface and the matching initiator.
// Contents: SPI mode constants (mode 0, MSB first) and the target FSM state type.
package spi_pkg;

   // Bus mode shared with the initiator: SCLK idles low, sample on rise, shift on fall.
   localparam bit SPI_CPOL      = 1'b0;
   localparam bit SPI_CPHA      = 1'b0;
   localparam bit SPI_MSB_FIRST = 1'b1;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      ACTIVE
   } spi_tgt_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle edge pulses.
// Ports:
//   clk, rst      system clock, asynchronous active-low reset
//   din           raw asynchronous input
//   level         synchronized level (SYNC_STG flops after din)
//   rise, fall    one-clk pulses on a synchronized 0->1 / 1->0 transition
module spi_sync_edge #(
   parameter int unsigned SYNC_STG = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [SYNC_STG-1:0] sync;
   logic                prev;

   // Chain resets to 0 on every pin. For CS_N this means the target must actually
   // observe CS_N high after reset before it will accept a frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync <= '0;
         prev <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STG-2:0], din};
         prev <= sync[SYNC_STG-1];
      end
   end

   assign level = sync[SYNC_STG-1];
   assign rise  = level & ~prev;
   assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target_if.sv
// SPI target (responder), mode 0, MSB first, oversampled on the system clock.
// Ports:
//   clk, rst                 system clock (>= 8x SCLK), asynchronous active-low reset
//   spi_sclk/cs_n/mosi       raw SPI inputs from the initiator
//   spi_miso, spi_miso_oe    serial data out and its pad output enable
//   tx_data/valid/ready      one-word transmit holding register, valid/ready handshake
//   rx_data, rx_valid        last received word and its one-cycle update pulse
//   busy                     frame in progress
//   frame_err                pulse: CS_N released with a partial word
//   tx_underrun              pulse: IDLE_WORD loaded because holding register was empty
module spi_target_if
   import spi_pkg::*;
#(
   parameter int unsigned       DATA_W    = 8,
   parameter logic [DATA_W-1:0] IDLE_WORD = 'hFF,
   parameter int unsigned       SYNC_STG  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              spi_sclk,
   input  logic              spi_cs_n,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy,
   output logic              frame_err,
   output logic              tx_underrun
);

   localparam int unsigned       CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

   logic sclk_rise, sclk_fall, unused_sclk_lvl;
   logic cs_lvl, cs_rise, cs_fall;
   logic mosi_lvl, unused_mosi_rise, unused_mosi_fall;

   spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_sclk (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_sclk),
      .level(unused_sclk_lvl),
      .rise (sclk_rise),
      .fall (sclk_fall)
   );

   spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_cs (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_cs_n),
      .level(cs_lvl),
      .rise (cs_rise),
      .fall (cs_fall)
   );

   spi_sync_edge #(.SYNC_STG(SYNC_STG)) u_sync_mosi (
      .clk  (clk),
      .rst  (rst),
      .din  (spi_mosi),
      .level(mosi_lvl),
      .rise (unused_mosi_rise),
      .fall (unused_mosi_fall)
   );

   spi_tgt_state_e    state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-2:0] shift_rx;   // MSB never needed: completed word is {shift_rx, mosi}
   logic [DATA_W-1:0] shift_tx;
   logic [DATA_W-1:0] hold_data;
   logic              hold_full;
   logic              rx_pend;
   logic              tx_load;
   logic              tx_shift;

   assign tx_ready = ~hold_full;

   // cs_rise takes priority over any SCLK edge in the same cycle.
   always_comb begin
      tx_load  = 1'b0;
      tx_shift = 1'b0;
      case (state)
         IDLE: begin
            tx_load = cs_fall;
         end
         ACTIVE: begin
            tx_load  = !cs_rise && sclk_fall && (bit_cnt == '0);
            tx_shift = !cs_rise && sclk_fall && (bit_cnt != '0);
         end
         default: begin
            tx_load  = 1'b0;
            tx_shift = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= WAIT_IDLE;
         bit_cnt     <= '0;
         shift_rx    <= '0;
         shift_tx    <= '0;
         hold_data   <= '0;
         hold_full   <= 1'b0;
         rx_data     <= '0;
         rx_pend     <= 1'b0;
         rx_valid    <= 1'b0;
         busy        <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
      end else begin
         rx_valid    <= rx_pend;
         rx_pend     <= 1'b0;
         frame_err   <= 1'b0;
         tx_underrun <= 1'b0;
         // MISO trails shift_tx by one cycle so it is a clean register output.
         spi_miso    <= (state == ACTIVE) ? shift_tx[DATA_W-1] : 1'b0;

         case (state)
            WAIT_IDLE: begin
               if (cs_lvl) state <= IDLE;
            end
            IDLE: begin
               if (cs_fall) begin
                  state       <= ACTIVE;
                  busy        <= 1'b1;
                  spi_miso_oe <= 1'b1;
                  bit_cnt     <= '0;
               end
            end
            ACTIVE: begin
               if (cs_rise) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  bit_cnt     <= '0;
                  if (bit_cnt != '0) frame_err <= 1'b1;
               end else if (sclk_rise) begin
                  shift_rx <= {shift_rx[DATA_W-3:0], mosi_lvl};
                  if (bit_cnt == CNT_LAST) begin
                     bit_cnt <= '0;
                     rx_data <= {shift_rx, mosi_lvl};
                     rx_pend <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end
            end
            default: state <= WAIT_IDLE;
         endcase

         // Holding register and transmit shifter. A load with an empty holding
         // register takes tx_data directly when it is valid that same cycle.
         if (tx_load) begin
            if (hold_full) begin
               shift_tx  <= hold_data;
               hold_full <= 1'b0;
            end else if (tx_valid) begin
               shift_tx <= tx_data;
            end else begin
               shift_tx    <= IDLE_WORD;
               tx_underrun <= 1'b1;
            end
         end else begin
            if (tx_valid && !hold_full) begin
               hold_data <= tx_data;
               hold_full <= 1'b1;
            end
            if (tx_shift) shift_tx <= {shift_tx[DATA_W-2:0], 1'b0};
         end
      end
   end

endmodule

// File: tb/tb_spi_target_if.sv
// Self-checking bench for spi_target_if: a mode-0 initiator model driving SCLK at clk/8,
// a table of directed frames, randomized frames against a queue-based reference model,
// and hand-written sequences for back-to-back, abort, bypass and mid-traffic reset.
module tb_spi_target_if;

   logic       clk;
   logic       rst;
   logic       spi_sclk;
   logic       spi_cs_n;
   logic       spi_mosi;
   logic       spi_miso;
   logic       spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       frame_err;
   logic       tx_underrun;

   spi_target_if #(
      .DATA_W   (8),
      .IDLE_WORD(8'hFF),
      .SYNC_STG (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .spi_sclk   (spi_sclk),
      .spi_cs_n   (spi_cs_n),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .spi_miso_oe(spi_miso_oe),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .busy       (busy),
      .frame_err  (frame_err),
      .tx_underrun(tx_underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Event monitor, sampled on the inactive clock edge.
   logic [7:0] rx_hist[$];
   int         und_cnt  = 0;
   int         ferr_cnt = 0;

   always @(negedge clk) begin
      if (rst) begin
         if (rx_valid) rx_hist.push_back(rx_data);
         if (tx_underrun) und_cnt++;
         if (frame_err) ferr_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_tx(input logic [7:0] d);
      int t;
      t = 0;
      while (tx_ready !== 1'b1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (t >= 200) check("tx_ready wait", {31'b0, tx_ready}, 32'd1);
      tx_data  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
   endtask

   // One SCLK period (8 clk). MISO is sampled just before the rising SCLK edge.
   // On the last bit CS_N rises together with the final SCLK fall.
   task automatic bit_xfer(input logic mb, input bit last, output logic sb);
      spi_mosi = mb;
      repeat (4) @(negedge clk);
      sb = spi_miso;
      spi_sclk = 1'b1;
      repeat (4) @(negedge clk);
      spi_sclk = 1'b0;
      if (last) spi_cs_n = 1'b1;
   endtask

   // Frame of nb bits; word w occupies mo/mi[8*w +: 8], MSB first.
   task automatic frame(input int nb, input logic [23:0] mo, output logic [23:0] mi,
                        output logic busy_mid);
      logic sb;
      mi       = '0;
      busy_mid = 1'b0;
      spi_cs_n = 1'b0;
      for (int k = 0; k < nb; k++) begin
         int w;
         int b;
         w = k / 8;
         b = 7 - (k % 8);
         bit_xfer(mo[8*w+b], k == nb - 1, sb);
         mi[8*w+b] = sb;
         if (k == 0) busy_mid = busy;
      end
      repeat (8) @(negedge clk);
   endtask

   // Reference: holding register as a queue; every word slot pops it or falls back to 0xFF.
   task automatic model(input bit pre, input logic [7:0] pw, input int n,
                        output logic [23:0] exp_mi, output int exp_und);
      logic [7:0] hq[$];
      exp_mi  = '0;
      exp_und = 0;
      if (pre) hq.push_back(pw);
      for (int w = 0; w < n; w++) begin
         if (hq.size() > 0) begin
            exp_mi[8*w +: 8] = hq.pop_front();
         end else begin
            exp_mi[8*w +: 8] = 8'hFF;
            exp_und++;
         end
      end
   endtask

   task automatic run_case(input string nm, input bit pre, input logic [7:0] pw, input int n,
                           input logic [23:0] mo, input logic [23:0] exp_mi, input int exp_und);
      logic [23:0] mi;
      logic        bm;
      int          rx0, u0, f0;
      if (pre) begin
         push_tx(pw);
         @(negedge clk);
         check({nm, " tx_ready low after preload"}, {31'b0, tx_ready}, 32'd0);
      end
      rx0 = rx_hist.size();
      u0  = und_cnt;
      f0  = ferr_cnt;
      frame(8 * n, mo, mi, bm);
      check({nm, " busy in frame"}, {31'b0, bm}, 32'd1);
      check({nm, " rx count"}, rx_hist.size() - rx0, n);
      check({nm, " underruns"}, und_cnt - u0, exp_und);
      check({nm, " frame_err"}, ferr_cnt - f0, 0);
      check({nm, " oe after"}, {31'b0, spi_miso_oe}, 32'd0);
      check({nm, " tx_ready after"}, {31'b0, tx_ready}, 32'd1);
      for (int w = 0; w < n; w++) begin
         check($sformatf("%s miso word %0d", nm, w), mi[8*w +: 8], exp_mi[8*w +: 8]);
         if (rx0 + w < rx_hist.size())
            check($sformatf("%s rx word %0d", nm, w), rx_hist[rx0+w], mo[8*w +: 8]);
      end
   endtask

   typedef struct {
      bit          pre;
      logic [7:0]  pw;
      int          n;
      logic [23:0] mo;
      logic [23:0] exp_mi;
      int          exp_und;
   } vec_t;

   vec_t vec[4];

   initial begin
      logic [23:0] mi;
      logic        bm;
      logic        sb;
      logic        busy_seen;
      int          rx0, u0, f0, t;

      vec[0] = '{1'b1, 8'hA5, 1, 24'h00003C, 24'h0000A5, 0};   // single word
      vec[1] = '{1'b0, 8'h00, 2, 24'h00C3E7, 24'h00FFFF, 2};   // underrun, 2 words
      vec[2] = '{1'b1, 8'h5A, 3, 24'h0180FF, 24'hFFFF5A, 2};   // preload then underrun
      vec[3] = '{1'b0, 8'h00, 1, 24'h000000, 24'h0000FF, 1};

      rst      = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("reset miso", {31'b0, spi_miso}, 32'd0);
      check("reset oe", {31'b0, spi_miso_oe}, 32'd0);
      check("reset tx_ready", {31'b0, tx_ready}, 32'd1);
      check("reset rx_data", {24'b0, rx_data}, 32'd0);
      check("reset rx_valid", {31'b0, rx_valid}, 32'd0);
      check("reset busy", {31'b0, busy}, 32'd0);
      check("reset frame_err", {31'b0, frame_err}, 32'd0);
      check("reset tx_underrun", {31'b0, tx_underrun}, 32'd0);
      rst = 1'b1;
      repeat (6) @(negedge clk);

      for (int i = 0; i < 4; i++)
         run_case($sformatf("vec%0d", i), vec[i].pre, vec[i].pw, vec[i].n, vec[i].mo,
                  vec[i].exp_mi, vec[i].exp_und);

      for (int i = 0; i < 8; i++) begin
         bit          pre;
         logic [7:0]  pw;
         int          n, eu;
         logic [23:0] mo, em;
         pre = 1'($urandom_range(0, 1));
         pw  = 8'($urandom);
         n   = $urandom_range(1, 3);
         mo  = 24'($urandom);
         model(pre, pw, n, em, eu);
         run_case($sformatf("rand%0d", i), pre, pw, n, mo, em, eu);
      end

      // Back-to-back: second word pushed mid-frame once the first has been loaded.
      push_tx(8'h11);
      rx0 = rx_hist.size();
      u0  = und_cnt;
      fork
         frame(16, 24'h004281, mi, bm);
         push_tx(8'h22);
      join
      check("b2b miso word 0", mi[7:0], 8'h11);
      check("b2b miso word 1", mi[15:8], 8'h22);
      check("b2b rx count", rx_hist.size() - rx0, 2);
      if (rx_hist.size() >= rx0 + 2) begin
         check("b2b rx word 0", rx_hist[rx0], 8'h81);
         check("b2b rx word 1", rx_hist[rx0+1], 8'h42);
      end
      check("b2b underruns", und_cnt - u0, 0);

      // Abort after 5 SCLKs, then a clean frame.
      rx0 = rx_hist.size();
      f0  = ferr_cnt;
      frame(5, 24'h0000FF, mi, bm);
      check("abort frame_err", ferr_cnt - f0, 1);
      check("abort rx count", rx_hist.size() - rx0, 0);
      check("abort oe", {31'b0, spi_miso_oe}, 32'd0);
      run_case("after abort", 1'b0, 8'h00, 1, 24'h00005A, 24'h0000FF, 1);

      // Bypass: tx_valid exactly in the cs_fall load cycle (2 clk after CS_N drops).
      u0 = und_cnt;
      fork
         frame(8, 24'h000033, mi, bm);
         begin
            @(negedge clk);
            @(negedge clk);
            tx_data  = 8'h96;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            check("bypass tx_ready stays 1", {31'b0, tx_ready}, 32'd1);
         end
      join
      check("bypass miso", mi[7:0], 8'h96);
      check("bypass underruns", und_cnt - u0, 0);

      // Reset mid-frame; released with CS_N still low, the frame must be ignored.
      push_tx(8'h77);
      spi_cs_n = 1'b0;
      for (int k = 0; k < 4; k++) bit_xfer(1'b1, 1'b0, sb);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("midrst miso", {31'b0, spi_miso}, 32'd0);
      check("midrst oe", {31'b0, spi_miso_oe}, 32'd0);
      check("midrst tx_ready", {31'b0, tx_ready}, 32'd1);
      check("midrst rx_data", {24'b0, rx_data}, 32'd0);
      check("midrst busy", {31'b0, busy}, 32'd0);
      rx0 = rx_hist.size();
      rst = 1'b1;
      busy_seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bit_xfer(k[0], 1'b0, sb);
         busy_seen = busy_seen | busy;
      end
      check("wait_idle busy", {31'b0, busy_seen}, 32'd0);
      check("wait_idle rx count", rx_hist.size() - rx0, 0);
      spi_cs_n = 1'b1;
      t = 0;
      while (busy !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (8) @(negedge clk);
      run_case("after midrst", 1'b0, 8'h00, 1, 24'h0000C3, 24'h0000FF, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
